mem_refill_responder: RTL and testbench

//  Main-memory side of the data-cache miss interface. Accepts one request at a time from the cache controller.

---
 rtl/mem_refill_responder.sv | 115 +++++++++++
 tb/tb_mem_refill_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_responder.sv
// rtl/mem_refill_responder.sv - main-memory responder for data-cache line refills and write-through words
module mem_refill_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LINE_WORDS  = 4,
    parameter int LATENCY     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [31:0]                   resp_data,
    output logic                          resp_last,
    output logic [$clog2(LINE_WORDS)-1:0] resp_idx,
    output logic                          busy
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int LW = $clog2(LINE_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [IW-LW-1:0] line_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic [IW-1:0]   req_index;
    logic            accept;
    logic            beat;
    logic            unused_addr_bits;

    logic [31:0] memory [DEPTH_WORDS];

    assign req_index        = req_addr[2 +: IW];
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:IW+2]};
    assign accept           = req_valid && req_ready;
    assign beat             = resp_valid && resp_ready;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        resp_data  = 32'd0;
        case (state)
            IDLE: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_d = write_q ? WACK : BURST;
            end
            BURST: begin
                resp_valid = 1'b1;
                resp_data  = memory[{line_q, resp_idx}];
                resp_last  = (resp_idx == LW'(LINE_WORDS - 1));
                if (beat && resp_last) state_d = IDLE;
            end
            WACK: begin
                resp_valid = 1'b1;
                resp_last  = 1'b1;
                resp_data  = wdata_q;
                if (beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // req_ready follows the next state so it drops on the accepting edge and rises on the final handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            line_q    <= '0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            resp_idx  <= '0;
        end else begin
            req_ready <= (state_d == IDLE);
            if (accept) begin
                cnt      <= CW'(LATENCY - 1);
                line_q   <= req_index[IW-1:LW];
                wdata_q  <= req_wdata;
                write_q  <= req_write;
                resp_idx <= '0;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == BURST && beat) begin
                resp_idx <= resp_idx + LW'(1);
            end
        end
    end

    // Backing array is deliberately not reset; writes commit on the accepting edge
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            memory[req_index] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_refill_responder.sv
// tb/tb_mem_refill_responder.sv - directed table-driven bench for mem_refill_responder
module tb_mem_refill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic [1:0]  resp_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_refill_responder #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .LATENCY(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_idx(resp_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] d0, d1, d2, d3;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic stall, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.stall = stall;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        logic [31:0] exp_d [4];
        int n;
        int b;
        int k;
        int guard;
        exp_d[0] = v.d0; exp_d[1] = v.d1; exp_d[2] = v.d2; exp_d[3] = v.d3;
        n = v.wr ? 1 : 4;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        tick();
        req_valid = 1'b0; req_write = ~v.wr; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
        chk("ready_drop_on_accept", req_ready, 0);
        chk("busy_after_accept", busy, 1);
        if (v.wr) chk("mem_write_commit", dut.memory[v.addr[11:2]], v.wdata);
        for (int e = 1; e <= 3; e++) begin
            chk("valid_before_latency", resp_valid, 0);
            tick();
        end
        b = 0; k = 0; guard = 0;
        while (b < n && guard < 40) begin
            chk("beat_valid", resp_valid, 1);
            chk("beat_data", resp_data, exp_d[b]);
            chk("beat_idx", resp_idx, v.wr ? 0 : b);
            chk("beat_last", resp_last, (b == n - 1) ? 1 : 0);
            resp_ready = v.stall ? (k % 3 == 0) : 1'b1;
            k++;
            tick();
            if (resp_ready) b++;
            guard++;
        end
        resp_ready = 1'b0;
        chk("beat_count", b, n);
        chk("ready_after_txn", req_ready, 1);
        chk("valid_after_txn", resp_valid, 0);
        chk("busy_after_txn", busy, 0);
    endtask

    initial begin
        int accepts;
        int beats;
        int second_acc;
        logic pre_acc;
        logic pre_beat;
        logic [31:0] line [4];

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; resp_ready = 1'b0;

        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_last", resp_last, 0);
        chk("rst_resp_idx", resp_idx, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        chk("ready_low_before_edge", req_ready, 0);
        tick();
        chk("ready_first_edge", req_ready, 1);

        tbl.push_back(mk(1, 32'd32,   32'd10, 0, 32'd10, 0, 0, 0));
        tbl.push_back(mk(1, 32'd36,   32'd20, 0, 32'd20, 0, 0, 0));
        tbl.push_back(mk(1, 32'd40,   32'd30, 0, 32'd30, 0, 0, 0));
        tbl.push_back(mk(1, 32'd44,   32'd40, 0, 32'd40, 0, 0, 0));
        tbl.push_back(mk(0, 32'd36,   0,      0, 32'd10, 32'd20, 32'd30, 32'd40));
        tbl.push_back(mk(1, 32'd1060, 32'd1,  0, 32'd1, 0, 0, 0));
        tbl.push_back(mk(1, 32'd1064, 32'd2,  0, 32'd2, 0, 0, 0));
        tbl.push_back(mk(1, 32'd1068, 32'd3,  0, 32'd3, 0, 0, 0));
        tbl.push_back(mk(1, 32'd1056, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 32'd1056, 0,      0, 32'hDEADBEEF, 32'd1, 32'd2, 32'd3));
        tbl.push_back(mk(0, 32'd32,   0,      1, 32'd10, 32'd20, 32'd30, 32'd40));
        tbl.push_back(mk(0, 32'd4128, 0,      0, 32'd10, 32'd20, 32'd30, 32'd40));
        tbl.push_back(mk(0, 32'd35,   0,      1, 32'd10, 32'd20, 32'd30, 32'd40));
        tbl.push_back(mk(0, 32'd4143, 0,      0, 32'd10, 32'd20, 32'd30, 32'd40));

        foreach (tbl[i]) do_txn(tbl[i]);
        chk("mem264", dut.memory[264], 32'hDEADBEEF);

        // Reset while beat 2 of a read is presented
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd32;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        resp_ready = 1'b1;
        tick(); tick(); tick();
        resp_ready = 1'b0;
        tick();
        chk("mid_idx_before_reset", resp_idx, 2);
        chk("mid_valid_before_reset", resp_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", resp_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_idx", resp_idx, 0);
        chk("async_rst_data", resp_data, 0);
        chk("async_rst_last", resp_last, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("ready_low_after_release", req_ready, 0);
        tick();
        chk("ready_after_release", req_ready, 1);
        chk("mem8_kept", dut.memory[8], 32'd10);
        chk("mem9_kept", dut.memory[9], 32'd20);
        chk("mem10_kept", dut.memory[10], 32'd30);
        chk("mem11_kept", dut.memory[11], 32'd40);
        do_txn(mk(0, 32'd32, 0, 0, 32'd10, 32'd20, 32'd30, 32'd40));

        // req_valid held high across two back-to-back reads
        line[0] = 32'd10; line[1] = 32'd20; line[2] = 32'd30; line[3] = 32'd40;
        accepts = 0; beats = 0; second_acc = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd32; resp_ready = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            pre_acc  = req_valid && req_ready;
            pre_beat = resp_valid && resp_ready;
            if (pre_beat) begin
                chk("held_beat_data", resp_data, line[beats % 4]);
                chk("held_beat_idx", resp_idx, beats % 4);
            end
            tick();
            if (pre_acc) begin
                accepts++;
                if (accepts == 2) second_acc = e;
            end
            if (pre_beat) beats++;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("held_accepts", accepts, 2);
        chk("held_second_accept_edge", second_acc, 9);
        chk("held_beats", beats, 8);
        chk("held_ready_end", req_ready, 1);
        chk("held_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
